// File: rtl/bit_manipulasyon_birim_bitcnt_pkg.sv
// Shared definitions for the bit-count / sign-extend unit.
// Contents:
//   bitcnt_op_e  - op select encoding {bit22, bit21, bit20}
//   xlen_legal() - datapath width check (32 or 64 only)
package bitmanip_pkg;

   typedef enum logic [2:0] {
      OP_CLZ      = 3'b000,
      OP_CTZ      = 3'b001,
      OP_PCNT     = 3'b010,
      OP_BMATFLIP = 3'b011,
      OP_SEXTB    = 3'b100,
      OP_SEXTH    = 3'b101,
      OP_RSVD6    = 3'b110,
      OP_RSVD7    = 3'b111
   } bitcnt_op_e;

   function automatic bit xlen_legal(input int xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

endpackage

// File: rtl/bit_manipulasyon_birim_bitcnt_if.sv
// Dispatcher-side handshake bundle for the bit-count unit.
// Input side : din_valid_i / din_ready_o, operand and decoded instruction bits.
// Output side: dout_valid_o / dout_ready_i, dout_result_o.
// master = dispatcher/consumer, slave = the execution unit.
interface bit_manipulasyon_birim_bitcnt_if #(
   parameter int XLEN = 32
) ();

   logic            din_valid_i;
   logic            din_ready_o;
   logic [XLEN-1:0] din_value1_i;
   logic            din_instruction_bit3_i;
   logic            din_instruction_bit20_i;
   logic            din_instruction_bit21_i;
   logic            din_instruction_bit22_i;
   logic            dout_valid_o;
   logic            dout_ready_i;
   logic [XLEN-1:0] dout_result_o;

   modport master (
      output din_valid_i,
      input  din_ready_o,
      output din_value1_i,
      output din_instruction_bit3_i,
      output din_instruction_bit20_i,
      output din_instruction_bit21_i,
      output din_instruction_bit22_i,
      input  dout_valid_o,
      output dout_ready_i,
      input  dout_result_o
   );

   modport slave (
      input  din_valid_i,
      output din_ready_o,
      input  din_value1_i,
      input  din_instruction_bit3_i,
      input  din_instruction_bit20_i,
      input  din_instruction_bit21_i,
      input  din_instruction_bit22_i,
      output dout_valid_o,
      input  dout_ready_i,
      output dout_result_o
   );

endinterface

// File: rtl/bit_manipulasyon_birim_bitcnt_core.sv
// Combinational datapath: CLZ, CTZ, PCNT, BMATFLIP, SEXT.B, SEXT.H.
// Ports:
//   src    - operand (rs1)
//   op     - decoded operation
//   w      - W-variant request (32-bit count on RV64), ignored for XLEN==32
//   result - zero-extended count, flipped matrix or sign-extended value
// CTZ reuses the leading-zero counter on the bit-reversed operand.
module bitcnt_core
   import bitmanip_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int BMAT = 0
) (
   input  logic [XLEN-1:0] src,
   input  bitcnt_op_e      op,
   input  logic            w,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;

   logic            w_eff;
   logic [XLEN-1:0] src_rev;
   logic [XLEN-1:0] clz_full;
   logic [XLEN-1:0] clz_w;
   logic [XLEN-1:0] clz_src;
   logic [XLEN-1:0] pcnt_w;
   logic [XLEN-1:0] pcnt_src;
   logic [XLEN-1:0] bmat;
   logic [CW-1:0]   lz;
   logic [CW-1:0]   pc;

   assign w_eff = w && (XLEN == 64);

   genvar gi, gj;
   generate
      for (gi = 0; gi < XLEN; gi++) begin : g_rev
         assign src_rev[gi] = src[XLEN-1-gi];
      end
   endgenerate

   assign clz_full = (op == OP_CTZ) ? src_rev : src;

   generate
      if (XLEN == 64) begin : g_wvar
         logic [31:0] lo_rev;
         logic [31:0] lo_word;
         for (gi = 0; gi < 32; gi++) begin : g_lo_rev
            assign lo_rev[gi] = src[31-gi];
         end
         assign lo_word = (op == OP_CTZ) ? lo_rev : src[31:0];
         // Ones below the word cap the leading-zero count at 32 for a zero word.
         assign clz_w  = {lo_word, 32'hFFFF_FFFF};
         assign pcnt_w = {32'h0, src[31:0]};
      end else begin : g_nowvar
         assign clz_w  = clz_full;
         assign pcnt_w = src;
      end
   endgenerate

   assign clz_src  = w_eff ? clz_w  : clz_full;
   assign pcnt_src = w_eff ? pcnt_w : src;

   // Highest set bit wins because the scan runs upward.
   always_comb begin
      lz = CW'(XLEN);
      for (int i = 0; i < XLEN; i++) begin
         if (clz_src[i]) lz = CW'(XLEN - 1 - i);
      end
   end

   always_comb begin
      pc = '0;
      for (int i = 0; i < XLEN; i++) begin
         pc = pc + CW'(pcnt_src[i]);
      end
   end

   generate
      if (XLEN == 64 && BMAT == 1) begin : g_bmat
         for (gi = 0; gi < 8; gi++) begin : g_row
            for (gj = 0; gj < 8; gj++) begin : g_col
               assign bmat[8*gi+gj] = src[8*gj+gi];
            end
         end
      end else begin : g_nobmat
         assign bmat = '0;
      end
   endgenerate

   always_comb begin
      result = '0;
      case (op)
         OP_CLZ,
         OP_CTZ:      result = XLEN'(lz);
         OP_PCNT:     result = XLEN'(pc);
         OP_BMATFLIP: result = bmat;
         OP_SEXTB:    result = {{(XLEN-8){src[7]}}, src[7:0]};
         OP_SEXTH:    result = {{(XLEN-16){src[15]}}, src[15:0]};
         default:     result = '0;
      endcase
   end

endmodule

// File: rtl/bit_manipulasyon_birim_bitcnt.sv
// Bit-count / sign-extend execution unit with a one-deep registered output.
// Ports:
//   clk_i - clock, rising edge
//   rst_i - asynchronous active-high reset, clears valid and result
//   bus   - handshake bundle (slave side): operand/op in, result out
// Accept when din_valid && din_ready; result is visible the following cycle.
module bit_manipulasyon_birim_bitcnt
   import bitmanip_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int BMAT = 0
) (
   input logic clk_i,
   input logic rst_i,
   bit_manipulasyon_birim_bitcnt_if.slave bus
);

   generate
      if (!xlen_legal(XLEN)) begin : g_illegal_xlen
         $error("bit_manipulasyon_birim_bitcnt: XLEN must be 32 or 64");
      end
   endgenerate

   logic            dout_valid_reg;
   logic [XLEN-1:0] dout_result_reg;
   logic [XLEN-1:0] core_result;
   logic            accept;
   bitcnt_op_e      op;

   assign op = bitcnt_op_e'({bus.din_instruction_bit22_i,
                             bus.din_instruction_bit21_i,
                             bus.din_instruction_bit20_i});

   bitcnt_core #(
      .XLEN (XLEN),
      .BMAT (BMAT)
   ) u_core (
      .src    (bus.din_value1_i),
      .op     (op),
      .w      (bus.din_instruction_bit3_i),
      .result (core_result)
   );

   // The slot frees up in the same cycle the consumer drains it.
   assign bus.din_ready_o = !dout_valid_reg || bus.dout_ready_i;
   assign accept          = bus.din_valid_i && bus.din_ready_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dout_valid_reg  <= 1'b0;
         dout_result_reg <= '0;
      end else if (accept) begin
         dout_valid_reg  <= 1'b1;
         dout_result_reg <= core_result;
      end else if (dout_valid_reg && bus.dout_ready_i) begin
         dout_valid_reg  <= 1'b0;
      end
   end

   assign bus.dout_valid_o  = dout_valid_reg;
   assign bus.dout_result_o = dout_result_reg;

endmodule

// File: tb/tb_bit_manipulasyon_birim_bitcnt.sv
// Bench for the bit-count unit: one XLEN=32/BMAT=0 and one XLEN=64/BMAT=1
// instance driven side by side; directed spec cases, backpressure, async
// reset and randomized operations checked against a behavioural model.
module tb_bit_manipulasyon_birim_bitcnt;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   bit_manipulasyon_birim_bitcnt_if #(.XLEN(32)) if32 ();
   bit_manipulasyon_birim_bitcnt_if #(.XLEN(64)) if64 ();

   bit_manipulasyon_birim_bitcnt #(.XLEN(32), .BMAT(0)) dut32 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if32.slave)
   );

   bit_manipulasyon_birim_bitcnt #(.XLEN(64), .BMAT(1)) dut64 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if64.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
      end
   endtask

   // Reference: counts by direct scanning, matrix flip by index formula.
   function automatic logic [63:0] ref_model(input int xlen, input bit bmat,
                                              input logic [63:0] src,
                                              input logic [2:0] op, input bit w);
      logic [63:0] r;
      int n;
      r = '0;
      n = (xlen == 64 && w) ? 32 : xlen;
      case (op)
         3'd0: begin
            r = 64'(n);
            for (int i = n - 1; i >= 0; i--) if (src[i]) begin r = 64'(n - 1 - i); break; end
         end
         3'd1: begin
            r = 64'(n);
            for (int i = 0; i < n; i++) if (src[i]) begin r = 64'(i); break; end
         end
         3'd2: for (int i = 0; i < n; i++) r = r + 64'(src[i]);
         3'd3: if (xlen == 64 && bmat)
                  for (int i = 0; i < 8; i++)
                     for (int j = 0; j < 8; j++) r[8*i+j] = src[8*j+i];
         3'd4: r = 64'($signed(src[7:0]));
         3'd5: r = 64'($signed(src[15:0]));
         default: r = '0;
      endcase
      if (xlen == 32) r[63:32] = '0;
      return r;
   endfunction

   task automatic drive(input logic din_v, input logic [63:0] src, input logic [2:0] op,
                        input bit w, input logic dout_r);
      if32.din_valid_i = din_v;  if64.din_valid_i = din_v;
      if32.din_value1_i = src[31:0]; if64.din_value1_i = src;
      if32.din_instruction_bit3_i = w;  if64.din_instruction_bit3_i = w;
      {if32.din_instruction_bit22_i, if32.din_instruction_bit21_i, if32.din_instruction_bit20_i} = op;
      {if64.din_instruction_bit22_i, if64.din_instruction_bit21_i, if64.din_instruction_bit20_i} = op;
      if32.dout_ready_i = dout_r; if64.dout_ready_i = dout_r;
   endtask

   // One accepted op per call; consecutive calls keep valid high (1 op/cycle).
   task automatic op_both(input string tag, input logic [63:0] src, input logic [2:0] op,
                          input bit w, input bit use_const,
                          input logic [63:0] e32, input logic [63:0] e64);
      logic [63:0] x32, x64;
      x32 = use_const ? e32 : ref_model(32, 1'b0, src, op, w);
      x64 = use_const ? e64 : ref_model(64, 1'b1, src, op, w);
      @(negedge clk);
      drive(1'b1, src, op, w, 1'b1);
      #1;
      check_val({tag, " rdy32"}, 64'(if32.din_ready_o), 64'd1);
      @(posedge clk);
      #1;
      $display("op %s src=0x%016h op=%0d w=%0d r32=0x%08h r64=0x%016h",
               tag, src, op, w, if32.dout_result_o, if64.dout_result_o);
      check_val({tag, " vld32"}, 64'(if32.dout_valid_o), 64'd1);
      check_val({tag, " res32"}, 64'(if32.dout_result_o), x32);
      check_val({tag, " vld64"}, 64'(if64.dout_valid_o), 64'd1);
      check_val({tag, " res64"}, if64.dout_result_o, x64);
   endtask

   typedef struct {
      logic [63:0] src;
      logic [2:0]  op;
      bit          w;
      logic [63:0] e32;
      logic [63:0] e64;
   } vec_t;

   vec_t dir_vecs[] = '{
      '{64'h0000_0000_F000_0000, 3'd0, 1'b0, 64'd0,  64'd32},
      '{64'h0000_0000_F000_0000, 3'd1, 1'b0, 64'd28, 64'd28},
      '{64'h0000_0000_F000_0000, 3'd2, 1'b0, 64'd4,  64'd4},
      '{64'h0,                   3'd0, 1'b0, 64'd32, 64'd64},
      '{64'h0,                   3'd1, 1'b0, 64'd32, 64'd64},
      '{64'h0000_0000_FFFF_FFFF, 3'd2, 1'b0, 64'd32, 64'd32},
      '{64'h0000_0000_0000_0001, 3'd0, 1'b0, 64'd31, 64'd63},
      '{64'h0000_0000_0000_00FF, 3'd4, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF},
      '{64'h0000_0000_0000_017F, 3'd4, 1'b0, 64'h7F,   64'h7F},
      '{64'h0000_0000_0000_FFFF, 3'd5, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF},
      '{64'h0000_0000_1234_7FFF, 3'd5, 1'b0, 64'h7FFF, 64'h7FFF},
      '{64'h0000_0000_AA55_AA55, 3'd3, 1'b0, 64'd0, 64'h0A05_0A05_0A05_0A05},
      '{64'h8040_2010_0804_0201, 3'd3, 1'b0, 64'd0, 64'h8040_2010_0804_0201},
      '{64'h0000_0000_0000_00FF, 3'd3, 1'b1, 64'd0, 64'h0101_0101_0101_0101},
      '{64'hAA55_AA55_AA55_AA55, 3'd6, 1'b0, 64'd0, 64'd0},
      '{64'hFFFF_FFFF_0000_0000, 3'd0, 1'b1, 64'd32, 64'd32},
      '{64'h8000_0000_0001_0000, 3'd0, 1'b1, 64'd15, 64'd15},
      '{64'h8000_0000_0000_0000, 3'd1, 1'b1, 64'd32, 64'd32},
      '{64'hFFFF_FFFF_0000_000F, 3'd2, 1'b1, 64'd4,  64'd4},
      '{64'hFFFF_FFFF_0000_0080, 3'd4, 1'b1, 64'hFFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80}
   };

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      drive(1'b0, 64'h0, 3'd0, 1'b0, 1'b0);
      #1;
      check_val("rst vld32", 64'(if32.dout_valid_o), 64'd0);
      check_val("rst res32", 64'(if32.dout_result_o), 64'd0);
      check_val("rst rdy32", 64'(if32.din_ready_o), 64'd1);
      check_val("rst vld64", 64'(if64.dout_valid_o), 64'd0);
      check_val("rst res64", if64.dout_result_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("idle vld32", 64'(if32.dout_valid_o), 64'd0);
      check_val("idle res32", 64'(if32.dout_result_o), 64'd0);
      check_val("idle rdy32", 64'(if32.din_ready_o), 64'd1);

      // Directed, back-to-back with dout_ready held high
      foreach (dir_vecs[k])
         op_both($sformatf("dir%0d", k), dir_vecs[k].src, dir_vecs[k].op, dir_vecs[k].w,
                 1'b1, dir_vecs[k].e32, dir_vecs[k].e64);
      @(negedge clk);
      drive(1'b0, 64'h0, 3'd0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check_val("drain vld32", 64'(if32.dout_valid_o), 64'd0);
      check_val("drain hold32", 64'(if32.dout_result_o), 64'hFFFF_FF80);

      // Backpressure: PCNT(0xF0000000)=4 pending, consumer stalled
      @(negedge clk);
      drive(1'b1, 64'h0000_0000_F000_0000, 3'd2, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_val("bp acc vld32", 64'(if32.dout_valid_o), 64'd1);
      check_val("bp acc res32", 64'(if32.dout_result_o), 64'd4);
      @(negedge clk);
      drive(1'b1, 64'h0000_0000_0000_000F, 3'd0, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         check_val($sformatf("bp%0d rdy32", c), 64'(if32.din_ready_o), 64'd0);
         @(posedge clk);
         #1;
         $display("hold c=%0d vld32=%0d res32=0x%08h", c, if32.dout_valid_o, if32.dout_result_o);
         check_val($sformatf("bp%0d vld32", c), 64'(if32.dout_valid_o), 64'd1);
         check_val($sformatf("bp%0d res32", c), 64'(if32.dout_result_o), 64'd4);
         @(negedge clk);
      end
      drive(1'b0, 64'h0, 3'd0, 1'b0, 1'b1);
      #1;
      check_val("bp release rdy32", 64'(if32.din_ready_o), 64'd1);
      @(posedge clk);
      #1;
      check_val("bp xfer vld32", 64'(if32.dout_valid_o), 64'd0);
      check_val("bp xfer res32", 64'(if32.dout_result_o), 64'd4);

      // Reset mid-hold discards the pending result immediately
      @(negedge clk);
      drive(1'b1, 64'h0000_0000_0000_0080, 3'd4, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_val("pre-rst vld32", 64'(if32.dout_valid_o), 64'd1);
      drive(1'b0, 64'h0, 3'd0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_val("async rst vld32", 64'(if32.dout_valid_o), 64'd0);
      check_val("async rst res32", 64'(if32.dout_result_o), 64'd0);
      check_val("async rst vld64", 64'(if64.dout_valid_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Randomized, biased toward zero / sparse / dense operands
      for (int t = 0; t < 300; t++) begin
         logic [63:0] s;
         int mode;
         mode = int'($urandom_range(0, 5));
         s = {$urandom(), $urandom()};
         case (mode)
            0: s = '0;
            1: s = 64'(1) << $urandom_range(0, 63);
            2: s = ~(64'(1) << $urandom_range(0, 63));
            3: s = s >> $urandom_range(0, 63);
            default: ;
         endcase
         op_both($sformatf("rnd%0d", t), s, 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                 1'b0, 64'h0, 64'h0);
      end
      @(negedge clk);
      drive(1'b0, 64'h0, 3'd0, 1'b0, 1'b1);
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
